// File: rtl/ps2_pkg.sv
// ps2_pkg: shared PS/2 constants and the frame parity check.
// Used by the receiver and by the scan-code consumers downstream.
package ps2_pkg;

  // Start + 8 data + parity + stop
  localparam int unsigned PS2_FRAME_BITS = 11;
  localparam logic [7:0]  PS2_BREAK_CODE = 8'hF0;
  localparam logic [7:0]  PS2_EXT_CODE   = 8'hE0;

  // PS/2 uses odd parity: the data bits together with the parity bit
  // must contain an odd number of ones.
  function automatic logic odd_parity_ok(input logic [7:0] d, input logic p);
    return ^{d, p};
  endfunction

endpackage

// File: rtl/ps2_sync_edge.sv
// ps2_sync_edge: brings the asynchronous PS/2 pins into the clk domain
// and produces a one-cycle strobe on each falling edge of ps2_clk.
//   clk, clrn : system clock, async active-low reset
//   ps2_clk   : raw PS/2 clock pin
//   ps2_data  : raw PS/2 data pin
//   fall      : high for one clk cycle per ps2_clk falling edge
//   sdata     : synchronised data bit, aligned with fall
module ps2_sync_edge (
  input  logic clk,
  input  logic clrn,
  input  logic ps2_clk,
  input  logic ps2_data,
  output logic fall,
  output logic sdata
);

  logic [2:0] clk_sync_r;
  logic [1:0] data_sync_r;

  // Synchroniser chains; reset to 1 because both lines idle high.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      clk_sync_r  <= 3'b111;
      data_sync_r <= 2'b11;
    end else begin
      clk_sync_r  <= {clk_sync_r[1:0], ps2_clk};
      data_sync_r <= {data_sync_r[0], ps2_data};
    end
  end

  // Edge detect uses only the two already-settled stages.
  assign fall  = (clk_sync_r[2:1] == 2'b10);
  assign sdata = data_sync_r[1];

endmodule

// File: rtl/ps2_rx_fifo.sv
// ps2_rx_fifo: PS/2 device-to-host receiver feeding a small byte FIFO.
//   clk, clrn          : system clock, async active-low reset
//   ps2_clk, ps2_data  : raw PS/2 pins
//   nextdata_n         : active-low pop request
//   data               : FIFO head byte (valid while ready)
//   ready              : FIFO non-empty
//   overflow           : sticky, a valid byte was dropped on a full FIFO
//   frame_err          : one-cycle pulse for a bad start/parity/stop
module ps2_rx_fifo
  import ps2_pkg::*;
#(
  parameter int unsigned DEPTH_LOG2     = 3,
  parameter int unsigned TIMEOUT_CYCLES = 10000
) (
  input  logic       clk,
  input  logic       clrn,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  input  logic       nextdata_n,
  output logic [7:0] data,
  output logic       ready,
  output logic       overflow,
  output logic       frame_err
);

  localparam int unsigned DEPTH  = 1 << DEPTH_LOG2;
  localparam int unsigned PTR_W  = DEPTH_LOG2 + 1;
  localparam int unsigned IDLE_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [3:0]        LAST_BIT   = 4'(PS2_FRAME_BITS - 1);
  localparam logic [IDLE_W-1:0] IDLE_LIMIT = IDLE_W'(TIMEOUT_CYCLES);

  logic              fall_s;
  logic              sdata_s;
  logic [3:0]        bit_cnt_r;
  logic [9:0]        shift_r;
  logic [IDLE_W-1:0] idle_cnt_r;
  logic [PTR_W-1:0]  w_ptr_r;
  logic [PTR_W-1:0]  r_ptr_r;
  logic [7:0]        mem_r [DEPTH];
  logic              overflow_r;
  logic              frame_err_r;

  logic empty_s, full_s, pop_s, stop_s, frame_ok_s, push_s, drop_s, idle_hit_s;

  ps2_sync_edge u_sync (
    .clk      (clk),
    .clrn     (clrn),
    .ps2_clk  (ps2_clk),
    .ps2_data (ps2_data),
    .fall     (fall_s),
    .sdata    (sdata_s)
  );

  // shift_r holds start in bit 0, D0..D7 in bits 8:1, parity in bit 9;
  // the stop bit is the live sample on the final edge.
  assign empty_s    = (w_ptr_r == r_ptr_r);
  assign full_s     = (w_ptr_r[PTR_W-1] != r_ptr_r[PTR_W-1]) &&
                      (w_ptr_r[PTR_W-2:0] == r_ptr_r[PTR_W-2:0]);
  assign pop_s      = !nextdata_n && !empty_s;
  assign stop_s     = fall_s && (bit_cnt_r == LAST_BIT);
  assign frame_ok_s = !shift_r[0] && sdata_s && odd_parity_ok(shift_r[8:1], shift_r[9]);
  // A pop on the same edge frees a slot, so a full FIFO can still accept.
  assign push_s     = stop_s && frame_ok_s && (!full_s || pop_s);
  assign drop_s     = stop_s && frame_ok_s && full_s && !pop_s;
  assign idle_hit_s = ((idle_cnt_r + IDLE_W'(1)) == IDLE_LIMIT);

  // Bit counter, shift register and partial-frame timeout.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      bit_cnt_r  <= 4'd0;
      shift_r    <= 10'd0;
      idle_cnt_r <= '0;
    end else if (fall_s) begin
      idle_cnt_r <= '0;
      shift_r    <= {sdata_s, shift_r[9:1]};
      bit_cnt_r  <= (bit_cnt_r == LAST_BIT) ? 4'd0 : bit_cnt_r + 4'd1;
    end else if (bit_cnt_r != 4'd0) begin
      if (idle_hit_s) begin
        bit_cnt_r  <= 4'd0;
        idle_cnt_r <= '0;
      end else begin
        idle_cnt_r <= idle_cnt_r + IDLE_W'(1);
      end
    end else begin
      idle_cnt_r <= '0;
    end
  end

  // FIFO storage; contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_r[w_ptr_r[PTR_W-2:0]] <= shift_r[8:1];
    end
  end

  // FIFO pointers and status flags.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      w_ptr_r     <= '0;
      r_ptr_r     <= '0;
      overflow_r  <= 1'b0;
      frame_err_r <= 1'b0;
    end else begin
      if (push_s) begin
        w_ptr_r <= w_ptr_r + PTR_W'(1);
      end
      if (pop_s) begin
        r_ptr_r <= r_ptr_r + PTR_W'(1);
      end
      if (pop_s) begin
        overflow_r <= 1'b0;
      end else if (drop_s) begin
        overflow_r <= 1'b1;
      end
      frame_err_r <= stop_s && !frame_ok_s;
    end
  end

  assign data      = mem_r[r_ptr_r[PTR_W-2:0]];
  assign ready     = !empty_s;
  assign overflow  = overflow_r;
  assign frame_err = frame_err_r;

endmodule

// File: tb/tb_ps2_rx_fifo.sv
module tb_ps2_rx_fifo;

  localparam int unsigned TMO = 10000;

  logic       clk;
  logic       clrn;
  logic       ps2_clk;
  logic       ps2_data;
  logic       nextdata_n;
  logic [7:0] data;
  logic       ready;
  logic       overflow;
  logic       frame_err;

  int n_cmp;
  int n_bad;
  int err_pulses;
  int e0;

  ps2_rx_fifo #(.DEPTH_LOG2(3), .TIMEOUT_CYCLES(TMO)) dut (
    .clk        (clk),
    .clrn       (clrn),
    .ps2_clk    (ps2_clk),
    .ps2_data   (ps2_data),
    .nextdata_n (nextdata_n),
    .data       (data),
    .ready      (ready),
    .overflow   (overflow),
    .frame_err  (frame_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count frame_err high cycles, sampled away from the active edge.
  initial err_pulses = 0;
  always @(negedge clk) if (frame_err === 1'b1) err_pulses++;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One PS/2 bit; the DUT samples on the third posedge after ps2_clk falls.
  // With pop_at_sample, nextdata_n is low for exactly that sampling edge.
  task automatic send_bit(input logic b, input logic pop_at_sample);
    @(negedge clk); ps2_data = b;
    repeat (3) @(negedge clk);
    ps2_clk = 1'b0;
    @(negedge clk);
    @(negedge clk);
    if (pop_at_sample) nextdata_n = 1'b0;
    @(negedge clk);
    nextdata_n = 1'b1;
    ps2_clk = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic bad_par, input logic pop_on_stop);
    logic par;
    par = (~^d) ^ bad_par;
    send_bit(1'b0, 1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i], 1'b0);
    send_bit(par, 1'b0);
    send_bit(1'b1, pop_on_stop);
  endtask

  task automatic pop();
    @(negedge clk); nextdata_n = 1'b0;
    @(negedge clk); nextdata_n = 1'b1;
  endtask

  initial begin
    logic [7:0] exp_b;
    n_cmp = 0;
    n_bad = 0;
    clrn = 1'b0; ps2_clk = 1'b1; ps2_data = 1'b1; nextdata_n = 1'b1;
    repeat (4) @(negedge clk);
    check("reset_ready", {31'd0, ready}, 32'd0);
    check("reset_overflow", {31'd0, overflow}, 32'd0);
    check("reset_frame_err", {31'd0, frame_err}, 32'd0);
    clrn = 1'b1;
    repeat (4) @(negedge clk);

    // Valid frame
    send_frame(8'h1C, 1'b0, 1'b0);
    check("valid_ready", {31'd0, ready}, 32'd1);
    check("valid_data", {24'd0, data}, 32'h1C);
    pop();
    check("valid_pop_ready", {31'd0, ready}, 32'd0);

    // Parity error, then a good break code
    e0 = err_pulses;
    send_frame(8'h1C, 1'b1, 1'b0);
    check("parerr_pulse", err_pulses - e0, 32'd1);
    check("parerr_ready", {31'd0, ready}, 32'd0);
    send_frame(8'hF0, 1'b0, 1'b0);
    check("f0_ready", {31'd0, ready}, 32'd1);
    check("f0_data", {24'd0, data}, 32'hF0);
    pop();
    check("f0_pop_ready", {31'd0, ready}, 32'd0);

    // Overflow on the ninth frame
    for (int i = 1; i <= 9; i++) begin
      send_frame(8'(i), 1'b0, 1'b0);
      if (i == 8) check("ovf_before", {31'd0, overflow}, 32'd0);
    end
    check("ovf_set", {31'd0, overflow}, 32'd1);
    check("ovf_head", {24'd0, data}, 32'h01);
    for (int i = 1; i <= 8; i++) begin
      check("ovf_pop_data", {24'd0, data}, 32'(i));
      pop();
      if (i == 1) check("ovf_clear", {31'd0, overflow}, 32'd0);
    end
    check("ovf_drained", {31'd0, ready}, 32'd0);

    // Full FIFO with a pop on the stop edge of 0x2A
    for (int i = 0; i < 8; i++) send_frame(8'h31 + 8'(i), 1'b0, 1'b0);
    check("full_head", {24'd0, data}, 32'h31);
    send_frame(8'h2A, 1'b0, 1'b1);
    check("simul_overflow", {31'd0, overflow}, 32'd0);
    for (int i = 0; i < 8; i++) begin
      exp_b = (i == 7) ? 8'h2A : 8'h32 + 8'(i);
      check("simul_order", {24'd0, data}, {24'd0, exp_b});
      pop();
    end
    check("simul_drained", {31'd0, ready}, 32'd0);

    // Partial frame abandoned by the timeout
    send_bit(1'b0, 1'b0);
    send_bit(1'b1, 1'b0);
    send_bit(1'b0, 1'b0);
    send_bit(1'b1, 1'b0);
    send_bit(1'b0, 1'b0);
    repeat (TMO + 10) @(negedge clk);
    e0 = err_pulses;
    send_frame(8'h1B, 1'b0, 1'b0);
    check("tmo_ready", {31'd0, ready}, 32'd1);
    check("tmo_data", {24'd0, data}, 32'h1B);
    check("tmo_no_err", err_pulses - e0, 32'd0);
    pop();

    // Reset during bit 6 of a frame with 3 bytes queued
    send_frame(8'h41, 1'b0, 1'b0);
    send_frame(8'h42, 1'b0, 1'b0);
    send_frame(8'h43, 1'b0, 1'b0);
    check("pre_rst_ready", {31'd0, ready}, 32'd1);
    for (int i = 0; i < 6; i++) send_bit(1'b1 ^ (i == 0), 1'b0);
    @(negedge clk); ps2_data = 1'b0;
    @(negedge clk); ps2_clk = 1'b0;
    clrn = 1'b0;
    #1;
    check("midrst_ready", {31'd0, ready}, 32'd0);
    repeat (2) @(negedge clk);
    ps2_clk = 1'b1; ps2_data = 1'b1;
    repeat (3) @(negedge clk);
    clrn = 1'b1;
    repeat (3) @(negedge clk);
    send_frame(8'h23, 1'b0, 1'b0);
    check("post_rst_ready", {31'd0, ready}, 32'd1);
    check("post_rst_data", {24'd0, data}, 32'h23);
    pop();
    check("post_rst_empty", {31'd0, ready}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
